// File: rtl/multichannel_handshake_sender.sv
// Multichannel 4-phase handshake sender: per-channel one-entry holding slots,
// round-robin arbitration, and a synchronized acknowledge from an asynchronous receiver.
module multichannel_handshake_sender #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    output logic [NUM_CH-1:0]       ready,
    output logic                    req_o,
    input  logic                    ack_i,
    output logic [WIDTH-1:0]        data_out,
    output logic [CH_W-1:0]         ch_out,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_LOW
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_s;
    logic [NUM_CH-1:0]      pending_q, pending_d;
    logic [WIDTH-1:0]       slot_q [NUM_CH];
    logic [WIDTH-1:0]       slot_d [NUM_CH];
    logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]        ch_out_q, ch_out_d;
    logic [WIDTH-1:0]       data_out_q, data_out_d;
    logic                   req_q, req_d;
    logic                   grant_vld;
    logic [CH_W-1:0]        grant_ch;
    int unsigned            cand;

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // Walk offsets from farthest to nearest so the nearest pending channel wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = 32'(rr_ptr_q) + (NUM_CH - 1 - k);
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (pending_q[CH_W'(cand)]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'(cand);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (grant_vld && !ack_s) state_d = REQ;
            REQ:      if (ack_s)               state_d = WAIT_LOW;
            WAIT_LOW: if (!ack_s)              state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_i};
        pending_d  = pending_q;
        slot_d     = slot_q;
        rr_ptr_d   = rr_ptr_q;
        ch_out_d   = ch_out_q;
        data_out_d = data_out_q;
        req_d      = req_q;

        // Loads only touch empty slots, so a granted or in-flight slot is never overwritten.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (start[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                slot_d[i]    = data_in[i*WIDTH +: WIDTH];
            end
        end

        case (state_q)
            IDLE: begin
                if (state_d == REQ) begin
                    req_d      = 1'b1;
                    ch_out_d   = grant_ch;
                    data_out_d = slot_q[grant_ch];
                    rr_ptr_d   = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
                end
            end
            REQ: begin
                if (state_d == WAIT_LOW) begin
                    req_d = 1'b0;
                end
            end
            WAIT_LOW: begin
                if (state_d == IDLE) begin
                    pending_d[ch_out_q] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_sync_q <= '0;
            pending_q  <= '0;
            slot_q     <= '{default: '0};
            rr_ptr_q   <= '0;
            ch_out_q   <= '0;
            data_out_q <= '0;
            req_q      <= 1'b0;
        end else begin
            ack_sync_q <= ack_sync_d;
            pending_q  <= pending_d;
            slot_q     <= slot_d;
            rr_ptr_q   <= rr_ptr_d;
            ch_out_q   <= ch_out_d;
            data_out_q <= data_out_d;
            req_q      <= req_d;
        end
    end

    assign ready    = ~pending_q;
    assign req_o    = req_q;
    assign data_out = data_out_q;
    assign ch_out   = ch_out_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_multichannel_handshake_sender.sv
// Directed bench for multichannel_handshake_sender: a default instance and a
// WIDTH=8 / NUM_CH=3 / SYNC_STAGES=3 instance, each driven by a modelled receiver.
module tb_multichannel_handshake_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst0;
    logic [3:0]   start0;
    logic [127:0] din0;
    logic [3:0]   rdy0;
    logic         req0;
    logic         ack0 = 1'b0;
    logic [31:0]  dout0;
    logic [1:0]   ch0;
    logic         busy0;

    logic         rst1;
    logic [2:0]   start1;
    logic [23:0]  din1;
    logic [2:0]   rdy1;
    logic         req1;
    logic         ack1 = 1'b0;
    logic [7:0]   dout1;
    logic [1:0]   ch1;
    logic         busy1;

    multichannel_handshake_sender #(.WIDTH(32), .NUM_CH(4), .SYNC_STAGES(2)) dut0 (
        .clock(clk), .reset(rst0), .start(start0), .data_in(din0), .ready(rdy0),
        .req_o(req0), .ack_i(ack0), .data_out(dout0), .ch_out(ch0), .busy(busy0)
    );

    multichannel_handshake_sender #(.WIDTH(8), .NUM_CH(3), .SYNC_STAGES(3)) dut1 (
        .clock(clk), .reset(rst1), .start(start1), .data_in(din1), .ready(rdy1),
        .req_o(req1), .ack_i(ack1), .data_out(dout1), .ch_out(ch1), .busy(busy1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver modes: 0 = ack mirrors req in the same cycle, 1 = one cycle later, 2 = manual
    int   rx_mode0 = 1;
    int   rx_mode1 = 0;
    logic seen0 = 1'b0;
    logic seen1 = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rx_mode0 == 0) ack0 = req0;
            else if (rx_mode0 == 1) ack0 = seen0;
            seen0 = req0;
            if (rx_mode1 == 0) ack1 = req1;
            else if (rx_mode1 == 1) ack1 = seen1;
            seen1 = req1;
        end
    end

    function automatic logic get_req(input int d);
        return (d == 0) ? req0 : req1;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction

    function automatic logic [3:0] get_rdy(input int d);
        return (d == 0) ? rdy0 : {1'b0, rdy1};
    endfunction

    function automatic logic [1:0] get_ch(input int d);
        return (d == 0) ? ch0 : ch1;
    endfunction

    function automatic logic [31:0] get_dout(input int d);
        return (d == 0) ? dout0 : {24'h0, dout1};
    endfunction

    task automatic load(input int d, input logic [3:0] mask,
                        input logic [31:0] v0, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] v3);
        if (d == 0) begin
            start0 = mask;
            din0   = {v3, v2, v1, v0};
        end else begin
            start1 = mask[2:0];
            din1   = {v2[7:0], v1[7:0], v0[7:0]};
        end
        tick();
        start0 = '0;
        start1 = '0;
    endtask

    task automatic wait_req(input int d, input logic level, input string tag);
        int n = 0;
        while (get_req(d) !== level && n < 100) begin
            tick();
            n++;
        end
        check_eq(tag, get_req(d), level);
    endtask

    task automatic wait_ready_all(input int d, input string tag);
        int n = 0;
        logic [3:0] full;
        full = (d == 0) ? 4'hF : 4'h7;
        while (get_rdy(d) !== full && n < 100) begin
            tick();
            n++;
        end
        check_eq(tag, get_rdy(d), full);
    endtask

    task automatic single(input int d, input logic [31:0] val, input int exp_lat);
        int n;
        logic [3:0] r;
        load(d, 4'b0100, 0, 0, val, 0);
        r = get_rdy(d);
        check_eq("single_ready_low", r[2], 1'b0);
        check_eq("single_req_not_yet", get_req(d), 1'b0);
        tick();
        check_eq("single_req_rise", get_req(d), 1'b1);
        check_eq("single_data_out", get_dout(d), val);
        check_eq("single_ch_out", get_ch(d), 2'd2);
        check_eq("single_busy", get_busy(d), 1'b1);
        n = 1;
        r = get_rdy(d);
        while (!r[2] && n < 100) begin
            tick();
            n++;
            r = get_rdy(d);
        end
        check_eq("single_latency", n, exp_lat);
        check_eq("single_idle_after", get_busy(d), 1'b0);
        check_eq("single_data_hold", get_dout(d), val);
    endtask

    task automatic expect_grant(input int d, input logic [1:0] exp_ch, input logic [31:0] exp_data);
        wait_req(d, 1'b1, "grant_req_up");
        check_eq("grant_ch_out", get_ch(d), exp_ch);
        check_eq("grant_data_out", get_dout(d), exp_data);
        wait_req(d, 1'b0, "grant_req_down");
    endtask

    task automatic count_quiet(input int d, input string tag);
        int rises = 0;
        repeat (20) begin
            tick();
            if (get_req(d)) rises++;
        end
        check_eq(tag, rises, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        rst0 = 1'b1; rst1 = 1'b1;
        start0 = '0; start1 = '0;
        din0 = '0; din1 = '0;
        repeat (2) tick();

        check_eq("rst_ready0", rdy0, 4'hF);
        check_eq("rst_req0", req0, 1'b0);
        check_eq("rst_busy0", busy0, 1'b0);
        check_eq("rst_ch0", ch0, 2'd0);
        check_eq("rst_dout0", dout0, 32'h0);
        check_eq("rst_ready1", rdy1, 3'h7);
        rst0 = 1'b0; rst1 = 1'b0;
        tick();

        // Receiver one cycle behind req: 2*2+5 cycles load to ready
        single(0, 32'hDEADBEEF, 9);
        rx_mode0 = 0;
        single(0, 32'h12345678, 7);

        load(0, 4'b1000, 0, 0, 0, 32'h55);
        wait_req(0, 1'b1, "rst_mid_req_up");
        rst0 = 1'b1;
        #1;
        check_eq("rst_mid_req", req0, 1'b0);
        check_eq("rst_mid_busy", busy0, 1'b0);
        check_eq("rst_mid_ch", ch0, 2'd0);
        check_eq("rst_mid_ready", rdy0, 4'hF);
        tick(); tick();
        rst0 = 1'b0;
        count_quiet(0, "rst_mid_no_req");

        load(0, 4'hF, 32'h10, 32'h11, 32'h12, 32'h13);
        expect_grant(0, 2'd0, 32'h10);
        expect_grant(0, 2'd1, 32'h11);
        expect_grant(0, 2'd2, 32'h12);
        expect_grant(0, 2'd3, 32'h13);
        wait_ready_all(0, "rr_drain");
        load(0, 4'b1001, 32'h20, 0, 0, 32'h23);
        expect_grant(0, 2'd0, 32'h20);
        expect_grant(0, 2'd3, 32'h23);
        wait_ready_all(0, "rr_drain2");

        load(0, 4'b0010, 0, 32'hAAAA, 0, 0);
        r = rdy0;
        check_eq("blocked_ready_low", r[1], 1'b0);
        load(0, 4'b0010, 0, 32'hBBBB, 0, 0);
        wait_req(0, 1'b1, "blocked_req_up");
        check_eq("blocked_data", dout0, 32'hAAAA);
        check_eq("blocked_ch", ch0, 2'd1);
        wait_ready_all(0, "blocked_drain");
        count_quiet(0, "blocked_dropped");
        check_eq("blocked_data_hold", dout0, 32'hAAAA);

        // Pointer sits at 2, so channel 0 wins first; ack_s then dips for one cycle only
        rx_mode0 = 2;
        ack0 = 1'b0;
        load(0, 4'b0011, 32'h77, 32'h88, 0, 0);
        wait_req(0, 1'b1, "stuck_req_up");
        check_eq("stuck_first_ch", ch0, 2'd0);
        ack0 = 1'b1;
        wait_req(0, 1'b0, "stuck_req_down");
        ack0 = 1'b0;
        tick();
        ack0 = 1'b1;
        repeat (4) tick();
        check_eq("stuck_idle_busy", busy0, 1'b0);
        check_eq("stuck_idle_req", req0, 1'b0);
        r = rdy0;
        check_eq("stuck_ch0_done", r[0], 1'b1);
        check_eq("stuck_ch1_pending", r[1], 1'b0);
        repeat (8) tick();
        check_eq("stuck_hold_req", req0, 1'b0);
        check_eq("stuck_hold_busy", busy0, 1'b0);
        ack0 = 1'b0;
        repeat (2) tick();
        check_eq("stuck_release_early", req0, 1'b0);
        tick();
        check_eq("stuck_release_req", req0, 1'b1);
        check_eq("stuck_release_ch", ch0, 2'd1);
        check_eq("stuck_release_data", dout0, 32'h88);
        rx_mode0 = 0;
        wait_ready_all(0, "stuck_drain");

        // Swept instance: 2*3+3 cycles load to ready, pointer wraps 2 -> 0
        single(1, 32'hDE, 9);
        load(1, 4'b0111, 32'h10, 32'h11, 32'h12, 0);
        expect_grant(1, 2'd0, 32'h10);
        expect_grant(1, 2'd1, 32'h11);
        expect_grant(1, 2'd2, 32'h12);
        wait_ready_all(1, "sweep_drain");
        load(1, 4'b0101, 32'h20, 0, 32'h22, 0);
        expect_grant(1, 2'd0, 32'h20);
        expect_grant(1, 2'd2, 32'h22);
        wait_ready_all(1, "sweep_drain2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multichannel_handshake_sender.md
MULTICHANNEL_HANDSHAKE_SENDER -- requirements
Module: multichannel_handshake_sender

Interface
REQ-001 Parameter WIDTH, default 32: payload width per channel, in bits; SHALL be >= 1.
REQ-002 Parameter NUM_CH, default 4: number of input channels; SHALL be >= 2.
REQ-003 Parameter SYNC_STAGES, default 2: number of flip-flop stages on ack_i; SHALL be >= 2.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  NUM_CH  per-channel load strobe.
REQ-008 data_in  input  NUM_CH*WIDTH  channel i payload in bits [i*WIDTH +: WIDTH].
REQ-009 ready  output  NUM_CH  channel i holding slot is empty.
REQ-010 req_o  output  1  4-phase request to the receiver.
REQ-011 ack_i  input  1  4-phase acknowledge, asynchronous to clock.
REQ-012 data_out  output  WIDTH  payload of the transfer in flight.
REQ-013 ch_out  output  max(1,$clog2(NUM_CH))  source channel of data_out.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Each channel SHALL have a one-entry holding slot with a pending flag; ready[i] SHALL equal the inverse of pending[i].
REQ-016 If start[i] and ready[i] are both high at a clock edge, that edge SHALL load slot i from its data_in slice and set pending[i].
REQ-017 If start[i] is high while ready[i] is low, the strobe SHALL be ignored and slot i SHALL remain unchanged.
REQ-018 ack_i SHALL pass through SYNC_STAGES flops, reset to 0, to form ack_s; the FSM SHALL use only ack_s.
REQ-019 The FSM SHALL have three states: IDLE, REQ and WAIT_LOW.
REQ-020 IDLE to REQ: taken when any pending bit is set and ack_s is 0.
  - On that edge, data_out, ch_out and req_o (set to 1) SHALL be loaded from the granted channel.
REQ-021 While ack_s is 1, IDLE SHALL NOT issue a grant.
REQ-022 REQ to WAIT_LOW: taken on the edge where ack_s is 1; req_o SHALL be 0 from that edge.
REQ-023 WAIT_LOW to IDLE: taken on the edge where ack_s is 0.
  - On that edge, pending[ch_out] SHALL be cleared, so ready[ch_out] is high the following cycle.
REQ-024 data_out and ch_out SHALL hold stable from entry to REQ until the next grant.
REQ-025 Arbitration SHALL be round-robin.
  - Search starts at (last granted channel + 1) mod NUM_CH.
  - After reset, the search starts at channel 0.
REQ-026 A slot that is granted or in flight SHALL NOT be overwritten.
  - start on that channel SHALL be ignored until ready returns high.
REQ-027 Same-edge events SHALL be handled as follows:
  - A load on channel j and a grant on another channel at the same edge SHALL both take effect.
  - A load on channel j is not visible to arbitration until the following edge.
REQ-028 Minimum latency SHALL be as follows:
  - req_o rises 1 cycle after the loading edge.
  - The complete handshake with an immediately responding receiver takes 2*SYNC_STAGES+3 cycles from load to ready high.
REQ-029 busy SHALL be high in REQ and in WAIT_LOW, and low in IDLE.

Reset
REQ-030 While reset is high, the following SHALL hold, asynchronously:
  - FSM in IDLE.
  - req_o=0, data_out=0, ch_out=0, busy=0.
  - All pending bits and slot contents 0; ready all ones.
  - Synchronizer flops 0; round-robin pointer at channel 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer.
  - After release, no req_o SHALL be issued until a new start is accepted.

Verification
REQ-032 Single transfer (WIDTH=32, NUM_CH=4):
  - Stimulus: start[2] with 32'hDEADBEEF; receiver raises ack 1 cycle after req_o and drops it 1 cycle after req_o falls.
  - Response: data_out=32'hDEADBEEF and ch_out=2 while req_o is high; ready[2] low until the handshake completes, then high.
REQ-033 Round-robin:
  - Stimulus: channels 0..3 loaded on the same edge with 0x10..0x13.
  - Response: grants in order 0,1,2,3.
  - Follow-on: reload 0 and 3 after 3 is granted → next grants are 0, then 3.
REQ-034 Blocked reload:
  - Stimulus: start[1] with 0xAAAA, then start[1] with 0xBBBB while ready[1]=0.
  - Response: 0xAAAA is delivered and 0xBBBB is dropped.
REQ-035 Stuck ack:
  - Stimulus: ack_i held high through the end of a handshake while another channel is pending.
  - Response: FSM stays in IDLE with req_o=0 until ack_i falls; the grant then follows after SYNC_STAGES cycles.
REQ-036 Reset mid-transfer:
  - Stimulus: reset asserted while in REQ.
  - Response: req_o, busy and ch_out are 0 immediately; ready is all ones.
  - After release, no req_o appears without a new start.
REQ-037 Parameter sweep: repeat REQ-032 and REQ-033 with WIDTH=8, NUM_CH=3, SYNC_STAGES=3, checking the latency in REQ-028.
